// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, sync/blank decode and a
// registered DAC stage that keeps color and sync aligned one pixel behind DrawX/DrawY.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       pixel_clk,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       frame_tick
);

  localparam int unsigned DivW   = $clog2(CLK_DIV);
  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);

  localparam logic [9:0] HLast      = 10'(HTotal - 1);
  localparam logic [9:0] HVis       = 10'(H_VISIBLE);
  localparam logic [9:0] HSyncFirst = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HSyncLast  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VLast      = 10'(VTotal - 1);
  localparam logic [9:0] VVis       = 10'(V_VISIBLE);
  localparam logic [9:0] VSyncFirst = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VSyncLast  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            pclk_q, pclk_d;
  logic [9:0]      hc_q, hc_d, vc_q, vc_d;
  logic [7:0]      r_q, r_d, g_q, g_d, b_q, b_d;
  logic            hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic            tick_q, tick_d;
  logic            pix_en, vis, hs_n, vs_n, h_last, v_last;

  always_comb begin
    pix_en = (div_q == DivLast);
    h_last = (hc_q == HLast);
    v_last = (vc_q == VLast);
    vis    = (hc_q < HVis) && (vc_q < VVis);
    hs_n   = !((hc_q >= HSyncFirst) && (hc_q <= HSyncLast));
    vs_n   = !((vc_q >= VSyncFirst) && (vc_q <= VSyncLast));

    div_d  = pix_en ? '0 : div_q + DivW'(1);
    // Registered from div_d so pixel_clk_q tracks the current div_q phase.
    pclk_d = (div_d >= DivHalf);

    hc_d      = hc_q;
    vc_d      = vc_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    tick_d    = 1'b0;

    if (pix_en) begin
      if (h_last) begin
        hc_d = '0;
        vc_d = v_last ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
      r_d       = vis ? Red   : 8'h00;
      g_d       = vis ? Green : 8'h00;
      b_d       = vis ? Blue  : 8'h00;
      hs_d      = hs_n;
      vs_d      = vs_n;
      blank_n_d = vis;
      tick_d    = h_last && v_last;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_q     <= '0;
      pclk_q    <= 1'b0;
      hc_q      <= '0;
      vc_q      <= '0;
      r_q       <= 8'h00;
      g_q       <= 8'h00;
      b_q       <= 8'h00;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      pclk_q    <= pclk_d;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      tick_q    <= tick_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign pixel_clk   = pclk_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign frame_tick  = tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size 640x480 instance for line timing/alignment, plus a shrunken
// CLK_DIV=4 instance so whole frames, vertical sync and frame_tick fit in a short run.
module tb_vga_timing_gen;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Full-size instance, Red follows DrawX so the one-pixel lag is visible.
  logic [9:0] dx, dy;
  logic       pclk, hs, vs, bn, ft;
  logic [7:0] r, g, b, red_in;
  assign red_in = dx[7:0];

  vga_timing_gen dut (
    .Clk(Clk), .Reset(Reset), .Red(red_in), .Green(8'h55), .Blue(8'h00),
    .DrawX(dx), .DrawY(dy), .pixel_clk(pclk), .VGA_R(r), .VGA_G(g), .VGA_B(b),
    .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(bn), .frame_tick(ft)
  );

  // Small instance: H 8+2+3+3=16, V 6+1+2+1=10, 4 Clk per pixel -> 640 Clk per frame.
  logic [9:0] sdx, sdy;
  logic       spclk, shs, svs, sbn, sft;
  logic [7:0] sr, sg, sb;

  vga_timing_gen #(
    .CLK_DIV(4), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_s (
    .Clk(Clk), .Reset(Reset), .Red(8'hff), .Green(8'h55), .Blue(8'ha5),
    .DrawX(sdx), .DrawY(sdy), .pixel_clk(spclk), .VGA_R(sr), .VGA_G(sg), .VGA_B(sb),
    .VGA_HS(shs), .VGA_VS(svs), .VGA_BLANK_N(sbn), .frame_tick(sft)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int p, phc, pvc, fall1, fall2, rise1;
    logic pvis, prev_hs;
    fall1 = -1; fall2 = -1; rise1 = -1;
    prev_hs = 1'b1;

    repeat (5) @(posedge Clk);
    @(negedge Clk);
    chk("rst_drawx", 32'(dx), 0);
    chk("rst_drawy", 32'(dy), 0);
    chk("rst_pclk", 32'(pclk), 0);
    chk("rst_rgb", {8'h0, r, g, b}, 0);
    chk("rst_hs", 32'(hs), 1);
    chk("rst_vs", 32'(vs), 1);
    chk("rst_blank_n", 32'(bn), 0);
    chk("rst_tick", 32'(ft), 0);
    chk("rst_s_tick", 32'(sft), 0);
    Reset = 1'b1;

    for (int cyc = 1; cyc <= 6200; cyc++) begin
      @(negedge Clk);
      // Full-size instance: pixel index = cyc/2, DAC shows the previous pixel.
      chk($sformatf("drawx@%0d", cyc), 32'(dx), (cyc / 2) % 800);
      chk($sformatf("drawy@%0d", cyc), 32'(dy), cyc / 1600);
      chk($sformatf("pclk@%0d", cyc), 32'(pclk), cyc % 2);
      chk($sformatf("tick@%0d", cyc), 32'(ft), 0);
      if (cyc < 2) begin
        chk("first_rgb", {8'h0, r, g, b}, 0);
        chk("first_hs_bn", {hs, vs, bn}, 3'b110);
      end else begin
        p = cyc / 2 - 1;
        phc = p % 800;
        pvc = p / 800;
        pvis = (phc < 640) && (pvc < 480);
        chk($sformatf("rgb@%0d", cyc), {8'h0, r, g, b},
            pvis ? {8'h0, 8'(phc), 8'h55, 8'h00} : 32'h0);
        chk($sformatf("blank_n@%0d", cyc), 32'(bn), 32'(pvis));
        chk($sformatf("hs@%0d", cyc), 32'(hs), (phc >= 656 && phc <= 751) ? 0 : 1);
        chk($sformatf("vs@%0d", cyc), 32'(vs), 1);
      end
      if (prev_hs && !hs) begin
        if (fall1 < 0) fall1 = cyc;
        else if (fall2 < 0) fall2 = cyc;
      end
      if (!prev_hs && hs && rise1 < 0) rise1 = cyc;
      prev_hs = hs;

      // Small instance: pixel index = cyc/4, 16 pixels/line, 10 lines/frame.
      chk($sformatf("s_drawx@%0d", cyc), 32'(sdx), (cyc / 4) % 16);
      chk($sformatf("s_drawy@%0d", cyc), 32'(sdy), (cyc / 64) % 10);
      chk($sformatf("s_pclk@%0d", cyc), 32'(spclk), ((cyc % 4) >= 2) ? 1 : 0);
      chk($sformatf("s_tick@%0d", cyc), 32'(sft), (cyc % 640 == 0) ? 1 : 0);
      if (cyc >= 4) begin
        p = cyc / 4 - 1;
        phc = p % 16;
        pvc = (p / 16) % 10;
        pvis = (phc < 8) && (pvc < 6);
        chk($sformatf("s_rgb@%0d", cyc), {8'h0, sr, sg, sb},
            pvis ? 32'h00ff55a5 : 32'h0);
        chk($sformatf("s_sync@%0d", cyc), {shs, svs, sbn},
            {(phc >= 10 && phc <= 12) ? 1'b0 : 1'b1,
             (pvc >= 7 && pvc <= 8) ? 1'b0 : 1'b1, pvis});
      end
    end

    chk("hs_first_fall", fall1, 1314);
    chk("hs_period", fall2 - fall1, 1600);
    chk("hs_low_width", rise1 - fall1, 192);

    // Asynchronous reset mid-line while HS is low: must clear before the next Clk edge.
    chk("pre_rst_drawx", 32'(dx), 700);
    chk("pre_rst_hs", 32'(hs), 0);
    #1 Reset = 1'b0;
    #1;
    chk("async_drawx", 32'(dx), 0);
    chk("async_drawy", 32'(dy), 0);
    chk("async_hs", 32'(hs), 1);
    chk("async_blank_n", 32'(bn), 0);
    chk("async_pclk", 32'(pclk), 0);
    chk("async_s_draw", {sdx, sdy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock. Drives DrawX/DrawY to color_mapper, and accepts color_mapper's Red/Green/Blue back in the same pixel. Registers blank-gated color together with HS/VS/BLANK_N toward the DAC, so sync and color stay pixel-aligned. Also provides a once-per-frame tick for game/board update logic.

Parameters:
CLK_DIV, 2, Clk cycles per pixel (50 MHz -> 25 MHz pixel rate); must be >=2 and even
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels); H_TOTAL = 800
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines); V_TOTAL = 525

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  asynchronous, active-low reset
Red, Green, Blue  in  8 each  pixel color from color_mapper for the current DrawX/DrawY
DrawX  out  10  current horizontal count hc (0..799)
DrawY  out  10  current vertical count vc (0..524)
pixel_clk  out  1  DAC pixel clock
VGA_R, VGA_G, VGA_B  out  8 each  registered, blank-gated color
VGA_HS, VGA_VS  out  1  registered sync, active-low
VGA_BLANK_N  out  1  registered, high in the visible region
frame_tick  out  1  one-Clk pulse at the end of each frame

Behaviour:
- Reset low (async): div=0, hc=0, vc=0, pixel_clk=0, VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, frame_tick=0. Reset asserted mid-frame clears state immediately, with no wait for Clk.
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_en = (div == CLK_DIV-1).
- pixel_clk is registered: high while div >= CLK_DIV/2, low otherwise. Outputs therefore change on pixel_clk falling edges, and the DAC samples mid-pixel on the rising edge.
- Counters advance only on Clk edges where pix_en=1:
  - hc: hc==799 -> 0 and vc advances; otherwise hc+1.
  - vc: vc==524 -> 0; otherwise vc+1.
- DrawX = hc and DrawY = vc, driven straight from the registers, with no added latency. Red/Green/Blue must be valid within the same Clk period.
- Decode from the current hc/vc:
  - vis = (hc < 640) && (vc < 480)
  - hs_n = !(656 <= hc <= 751)
  - vs_n = !(490 <= vc <= 491)
- Output stage, on Clk edges where pix_en=1:
  - VGA_R/G/B <= vis ? Red/Green/Blue : 0
  - VGA_HS <= hs_n, VGA_VS <= vs_n, VGA_BLANK_N <= vis
  - All DAC outputs lag DrawX/DrawY by exactly one pixel (CLK_DIV Clk cycles), with identical lag for color and sync.
- frame_tick: registered. Set to 1 on the pix_en edge where hc==799 and vc==524 (the wrap to 0,0). Cleared on the next Clk edge, so it is exactly one Clk wide, once per 840000 Clk.
- Widths: all compares on 10-bit unsigned values. Counters never exceed 799/524, and no overflow path exists.
- Inputs between pix_en edges are ignored.

Test Plan:
- Reset: Reset low 5 Clk -> all outputs at reset values. Release, run to hc=300/vc=100, assert Reset asynchronously between Clk edges -> DrawX=0, DrawY=0, VGA_HS=1 before the next Clk edge.
- Line timing: free-run -> VGA_HS period 1600 Clk, low pulse 192 Clk. First VGA_HS fall occurs on the pix_en edge where hc 656->657.
- Frame timing: free-run -> VGA_VS period 840000 Clk, low pulse 3200 Clk. frame_tick high exactly 1 Clk per 840000, coincident with DrawX/DrawY going 799/524 -> 0/0.
- Blanking: hold Red=8'hff, Green=8'h55, Blue=8'h00 -> VGA_R/G/B = ff/55/00 with VGA_BLANK_N=1 for 640 pixels per line on lines 0..479. Output is 0/0/0 with BLANK_N=0 for 160 pixels per line and for all of lines 480..524.
- Alignment: drive Red=DrawX[7:0] combinationally -> on each visible pixel, VGA_R equals the DrawX of the previous pixel. First visible output is 8'h00, with BLANK_N rising on the same edge.
- Divider/pixel_clk: CLK_DIV=2 -> pixel_clk toggles every Clk; counters advance every 2nd Clk. CLK_DIV=4 -> pixel_clk 2 high/2 low, and line period is 3200 Clk.
